csr_access_sequencer: RTL and testbench
=======================================

Name: csr_access_sequencer

Overview:
Serializes CSR instructions from NUM_REQS requesters onto the single-ported CSR data block's read and write ports. Each request is executed as a sequenced read-modify-write: CSRRW, CSRRS, CSRRC or read-only. Arbitration between requesters is round-robin. The block sits between the issue-side CSR units and the CSR data store, and drives that store's busy input.

Parameters:
NUM_REQS, 4, number of requesters; must be ≥2.
NW_BITS, 2, warp-id width.
UUID_BITS, 44, instruction uuid width.
ADDR_BITS, 12, CSR address width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQS  per-requester request valid
req_ready  out  NUM_REQS  per-requester accept (one-hot or zero)
req_op  in  NUM_REQS*2  per-requester op: 00 RW, 01 RS, 10 RC, 11 RO
req_addr  in  NUM_REQS*ADDR_BITS  CSR address
req_wid  in  NUM_REQS*NW_BITS  warp id
req_data  in  NUM_REQS*32  rs1/immediate operand
req_uuid  in  NUM_REQS*UUID_BITS  uuid
read_enable  out  1  CSR read strobe
read_addr  out  ADDR_BITS  CSR read address
read_wid  out  NW_BITS  CSR read warp
read_uuid  out  UUID_BITS  CSR read uuid
read_data  in  32  CSR read data, combinational from read_addr/read_wid
write_enable  out  1  CSR write strobe
write_addr  out  ADDR_BITS  CSR write address
write_wid  out  NW_BITS  CSR write warp
write_uuid  out  UUID_BITS  CSR write uuid
write_data  out  32  CSR write data
busy  out  1  high whenever the FSM is not IDLE or any req_valid is set
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_idx  out  log2(NUM_REQS)  requester index being answered
rsp_data  out  32  old CSR value (the rd result)
rsp_uuid  out  UUID_BITS  uuid of the answered request

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=NUM_REQS-1, all strobes/valids 0, all registered addr/data/uuid/idx outputs 0.
- FSM states: IDLE → READ → WRITE → RESP → IDLE.
- IDLE, grant:
  - If any req_valid is set, grant the first valid index searching upward from rr_ptr+1 (mod NUM_REQS).
  - req_ready[g]=1 combinationally in that cycle only.
  - Latch op/addr/wid/data/uuid and g; set rr_ptr=g; go to READ.
  - With no valid requests, stay in IDLE; req_ready=0.
- READ, one cycle:
  - read_enable=1; read_addr/wid/uuid come from the latched request.
  - Capture read_data into old_r at the clock edge; go to WRITE.
- WRITE, one cycle:
  - new value: RW → data; RS → old_r | data; RC → old_r & ~data.
  - write_enable=1 only if op==RW, or op∈{RS,RC} with data≠0. RO never writes.
  - write_data=new; write_addr/wid/uuid are latched values. Go to RESP.
- RESP:
  - rsp_valid=1; rsp_data=old_r; rsp_idx/rsp_uuid latched.
  - Hold while rsp_ready=0, with outputs stable. On rsp_ready=1, go to IDLE.
- No new grant is issued outside IDLE; req_ready=0 in READ, WRITE and RESP.
- Best-case throughput: one request per 4 cycles (grant, read, write, response).
- read_enable and write_enable are never asserted in the same cycle.
- Write strobe timing: the CSR store samples on the edge ending WRITE; the next read of the same CSR therefore observes the new value.
- Reset asserted mid-operation: immediate return to IDLE. The in-flight request is dropped with no write and no response; rr_ptr is restored to NUM_REQS-1.
- A requester may keep req_valid high after it is granted; it is treated as a new request and competes in the next IDLE cycle.

Test Plan:
1. req0 RW, addr 0x300, data 0xA5, CSR holds 0x11. Expect: read_enable in cycle 1; write_enable in cycle 2 with data 0xA5; rsp_data=0x11, rsp_idx=0.
2. req1 RS with data 0, CSR 0x7. Expect: write_enable stays 0 throughout; rsp_data=0x7. Repeat with data 0x8: write_data=0xF.
3. RC with data 0x3, CSR 0xF. Expect: write_data=0xC. RO op: no write; rsp_data equals the CSR value.
4. All four req_valid held high for 16 cycles after reset. Expect grant order 0,1,2,3,0… with req_ready one-hot, and exactly one grant per 4 cycles.
5. rsp_ready held low for 5 cycles in RESP. Expect rsp_valid, rsp_data and rsp_idx stable, no req_ready during the stall, and a grant in the cycle after the handshake.
6. Assert reset during the READ cycle of an RW. Expect: no write_enable, no rsp_valid, all outputs 0 asynchronously. After release, pending req0 is granted first.

Source files
------------

// File: rtl/csr_access_sequencer.sv
// Round-robin sequencer that runs one CSR read-modify-write at a time
// (grant, read, write, response) against a single-ported CSR store.
module csr_access_sequencer #(
    parameter int unsigned NUM_REQS  = 4,
    parameter int unsigned NW_BITS   = 2,
    parameter int unsigned UUID_BITS = 44,
    parameter int unsigned ADDR_BITS = 12
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQS-1:0]             req_valid,
    output logic [NUM_REQS-1:0]             req_ready,
    input  logic [NUM_REQS*2-1:0]           req_op,
    input  logic [NUM_REQS*ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_REQS*NW_BITS-1:0]     req_wid,
    input  logic [NUM_REQS*32-1:0]          req_data,
    input  logic [NUM_REQS*UUID_BITS-1:0]   req_uuid,
    output logic                            read_enable,
    output logic [ADDR_BITS-1:0]            read_addr,
    output logic [NW_BITS-1:0]              read_wid,
    output logic [UUID_BITS-1:0]            read_uuid,
    input  logic [31:0]                     read_data,
    output logic                            write_enable,
    output logic [ADDR_BITS-1:0]            write_addr,
    output logic [NW_BITS-1:0]              write_wid,
    output logic [UUID_BITS-1:0]            write_uuid,
    output logic [31:0]                     write_data,
    output logic                            busy,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [$clog2(NUM_REQS)-1:0]     rsp_idx,
    output logic [31:0]                     rsp_data,
    output logic [UUID_BITS-1:0]            rsp_uuid
);

    localparam int unsigned IDX_W = $clog2(NUM_REQS);

    localparam logic [1:0] OP_RW = 2'b00;
    localparam logic [1:0] OP_RS = 2'b01;
    localparam logic [1:0] OP_RC = 2'b10;
    localparam logic [1:0] OP_RO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       cand;
    logic                   grant_found;

    logic [1:0]             op_r;
    logic [ADDR_BITS-1:0]   addr_r;
    logic [NW_BITS-1:0]     wid_r;
    logic [31:0]            data_r;
    logic [UUID_BITS-1:0]   uuid_r;
    logic [IDX_W-1:0]       idx_r;
    logic [31:0]            old_r;

    logic [31:0]            new_val_c;
    logic                   wr_cond_c;

    // First valid requester searching upward from rr_ptr+1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            cand = IDX_W'((32'(rr_ptr) + 32'd1 + i) % NUM_REQS);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            ST_IDLE: begin
                if (reset && grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    state_next           = ST_READ;
                end
            end
            ST_READ:  state_next = ST_WRITE;
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Modified value is formed from the live read data during READ and registered.
    always_comb begin
        new_val_c = read_data;
        case (op_r)
            OP_RW: new_val_c = data_r;
            OP_RS: new_val_c = read_data | data_r;
            OP_RC: new_val_c = read_data & ~data_r;
            OP_RO: new_val_c = read_data;
        endcase
        wr_cond_c = (op_r == OP_RW) || (((op_r == OP_RS) || (op_r == OP_RC)) && (data_r != 32'd0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr       <= IDX_W'(NUM_REQS - 1);
            op_r         <= '0;
            addr_r       <= '0;
            wid_r        <= '0;
            data_r       <= '0;
            uuid_r       <= '0;
            idx_r        <= '0;
            old_r        <= '0;
            write_data   <= '0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            rsp_valid    <= 1'b0;
        end else begin
            read_enable  <= (state_next == ST_READ);
            write_enable <= (state_next == ST_WRITE) && wr_cond_c;
            rsp_valid    <= (state_next == ST_RESP);
            if (state == ST_IDLE && grant_found) begin
                rr_ptr <= grant_idx;
                idx_r  <= grant_idx;
                op_r   <= req_op[32'(grant_idx) * 2 +: 2];
                addr_r <= req_addr[32'(grant_idx) * ADDR_BITS +: ADDR_BITS];
                wid_r  <= req_wid[32'(grant_idx) * NW_BITS +: NW_BITS];
                data_r <= req_data[32'(grant_idx) * 32 +: 32];
                uuid_r <= req_uuid[32'(grant_idx) * UUID_BITS +: UUID_BITS];
            end
            if (state == ST_READ) begin
                old_r      <= read_data;
                write_data <= new_val_c;
            end
        end
    end

    assign read_addr  = addr_r;
    assign read_wid   = wid_r;
    assign read_uuid  = uuid_r;
    assign write_addr = addr_r;
    assign write_wid  = wid_r;
    assign write_uuid = uuid_r;
    assign rsp_idx    = idx_r;
    assign rsp_data   = old_r;
    assign rsp_uuid   = uuid_r;
    assign busy       = (state != ST_IDLE) || (|req_valid);

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Bench for csr_access_sequencer: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_csr_access_sequencer;

    localparam int unsigned N  = 4;
    localparam int unsigned NW = 2;
    localparam int unsigned UW = 44;
    localparam int unsigned AW = 12;
    localparam int unsigned KW = NW + AW;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*2-1:0]    req_op;
    logic [N*AW-1:0]   req_addr;
    logic [N*NW-1:0]   req_wid;
    logic [N*32-1:0]   req_data;
    logic [N*UW-1:0]   req_uuid;
    logic              read_enable;
    logic [AW-1:0]     read_addr;
    logic [NW-1:0]     read_wid;
    logic [UW-1:0]     read_uuid;
    logic [31:0]       read_data;
    logic              write_enable;
    logic [AW-1:0]     write_addr;
    logic [NW-1:0]     write_wid;
    logic [UW-1:0]     write_uuid;
    logic [31:0]       write_data;
    logic              busy;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_idx;
    logic [31:0]       rsp_data;
    logic [UW-1:0]     rsp_uuid;

    csr_access_sequencer #(
        .NUM_REQS(N), .NW_BITS(NW), .UUID_BITS(UW), .ADDR_BITS(AW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wid(req_wid), .req_data(req_data), .req_uuid(req_uuid),
        .read_enable(read_enable), .read_addr(read_addr), .read_wid(read_wid),
        .read_uuid(read_uuid), .read_data(read_data),
        .write_enable(write_enable), .write_addr(write_addr), .write_wid(write_wid),
        .write_uuid(write_uuid), .write_data(write_data),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_idx(rsp_idx), .rsp_data(rsp_data), .rsp_uuid(rsp_uuid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR store seen by the DUT, and the model's own copy of what it must hold.
    logic [31:0] mem     [0:(1<<KW)-1];
    logic [31:0] ref_mem [0:(1<<KW)-1];
    assign read_data = mem[{read_wid, read_addr}];

    int checks = 0;
    int errors = 0;

    // Model of the transaction in flight: 0 idle, 1 read, 2 write, 3 response.
    int          m_phase;
    int          m_rr;
    int          m_idx;
    logic [1:0]  m_op;
    logic [AW-1:0] m_addr;
    logic [NW-1:0] m_wid;
    logic [31:0] m_data, m_old, m_new;
    logic [UW-1:0] m_uuid;
    bit          m_wr;
    logic [N-1:0] gnt_mask;
    int          grants_q[$];

    int          obs_we, obs_rv;
    logic [31:0] obs_wdata, obs_rsp;
    int          obs_ridx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [NW-1:0] wid, input logic [31:0] data, input logic [UW-1:0] uuid);
        req_valid[i]          = 1'b1;
        req_op[i*2 +: 2]      = op;
        req_addr[i*AW +: AW]  = addr;
        req_wid[i*NW +: NW]   = wid;
        req_data[i*32 +: 32]  = data;
        req_uuid[i*UW +: UW]  = uuid;
    endtask

    task automatic preset(input logic [NW-1:0] wid, input logic [AW-1:0] addr, input logic [31:0] v);
        mem[{wid, addr}]     = v;
        ref_mem[{wid, addr}] = v;
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_rr    = N - 1;
    endtask

    task automatic clear_obs();
        obs_we = 0; obs_rv = 0; obs_wdata = '0; obs_rsp = '0; obs_ridx = -1;
    endtask

    // One clock: entered at a falling edge with inputs already driven.
    task automatic tick();
        logic [N-1:0] exp_ready;
        int           g;
        bit           we_s;
        logic [KW-1:0] wkey;
        logic [31:0]  wdat;
        #1;
        exp_ready = '0;
        g         = -1;
        gnt_mask  = '0;
        if (m_phase == 0 && (|req_valid)) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (req_valid[c]) begin
                    g = c;
                    break;
                end
            end
            exp_ready[g] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'((m_phase != 0) || (|req_valid)));

        case (m_phase)
            0: if (g >= 0) begin
                m_idx  = g;
                m_rr   = g;
                m_op   = req_op[g*2 +: 2];
                m_addr = req_addr[g*AW +: AW];
                m_wid  = req_wid[g*NW +: NW];
                m_data = req_data[g*32 +: 32];
                m_uuid = req_uuid[g*UW +: UW];
                m_old  = ref_mem[{m_wid, m_addr}];
                case (m_op)
                    2'd0:    m_new = m_data;
                    2'd1:    m_new = m_old | m_data;
                    2'd2:    m_new = m_old & ~m_data;
                    default: m_new = m_old;
                endcase
                m_wr = (m_op == 2'd0) || ((m_op == 2'd1 || m_op == 2'd2) && m_data != 0);
                m_phase = 1;
                gnt_mask[g] = 1'b1;
                grants_q.push_back(g);
            end
            1: m_phase = 2;
            2: begin
                if (m_wr) ref_mem[{m_wid, m_addr}] = m_new;
                m_phase = 3;
            end
            default: if (rsp_ready) m_phase = 0;
        endcase

        we_s = write_enable;
        wkey = {write_wid, write_addr};
        wdat = write_data;
        @(posedge clk);
        @(negedge clk);
        if (we_s) mem[wkey] = wdat;

        chk("read_enable", 64'(read_enable), 64'(m_phase == 1));
        if (m_phase == 1) begin
            chk("read_addr", 64'(read_addr), 64'(m_addr));
            chk("read_wid",  64'(read_wid),  64'(m_wid));
            chk("read_uuid", 64'(read_uuid), 64'(m_uuid));
        end
        chk("write_enable", 64'(write_enable), 64'(m_phase == 2 && m_wr));
        if (m_phase == 2 && m_wr) begin
            chk("write_addr", 64'(write_addr), 64'(m_addr));
            chk("write_wid",  64'(write_wid),  64'(m_wid));
            chk("write_uuid", 64'(write_uuid), 64'(m_uuid));
            chk("write_data", 64'(write_data), 64'(m_new));
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == 3));
        if (m_phase == 3) begin
            chk("rsp_idx",  64'(rsp_idx),  64'(m_idx));
            chk("rsp_data", 64'(rsp_data), 64'(m_old));
            chk("rsp_uuid", 64'(rsp_uuid), 64'(m_uuid));
        end
        if (write_enable) begin obs_we++; obs_wdata = write_data; end
        if (rsp_valid)    begin obs_rv++; obs_rsp = rsp_data; obs_ridx = int'(rsp_idx); end
    endtask

    // Single request with immediate response acceptance; four clocks.
    task automatic run_one(input int i, input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [NW-1:0] wid, input logic [31:0] data, input logic [31:0] csr);
        preset(wid, addr, csr);
        clear_obs();
        set_req(i, op, addr, wid, data, UW'(64'h100 + 64'(i)));
        rsp_ready = 1'b1;
        tick();
        req_valid[i] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_re"},   64'(read_enable),  64'(0));
        chk({tag, "_we"},   64'(write_enable), 64'(0));
        chk({tag, "_rv"},   64'(rsp_valid),    64'(0));
        chk({tag, "_rdy"},  64'(req_ready),    64'(0));
        chk({tag, "_addr"}, 64'(read_addr),    64'(0));
        chk({tag, "_wd"},   64'(write_data),   64'(0));
        chk({tag, "_rd"},   64'(rsp_data),     64'(0));
        chk({tag, "_idx"},  64'(rsp_idx),      64'(0));
        chk({tag, "_uuid"}, 64'(rsp_uuid),     64'(0));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b1;
    endtask

    task automatic rand_req(input int i);
        logic [AW-1:0] addrs [4];
        logic [31:0]   d;
        addrs[0] = 12'h300; addrs[1] = 12'h301; addrs[2] = 12'h305; addrs[3] = 12'h340;
        d = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        set_req(i, 2'($urandom_range(0, 3)), addrs[$urandom_range(0, 3)],
                NW'($urandom_range(0, 3)), d, UW'({$urandom, $urandom}));
    endtask

    initial begin
        reset = 1'b0;
        req_valid = '0; req_op = '0; req_addr = '0; req_wid = '0; req_data = '0; req_uuid = '0;
        rsp_ready = 1'b0;
        gnt_mask = '0;
        for (int a = 0; a < (1 << KW); a++) begin
            mem[a]     = $urandom;
            ref_mem[a] = mem[a];
        end
        model_reset();
        clear_obs();

        @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;

        // RW: old value returned, operand written.
        run_one(0, 2'd0, 12'h300, 2'd0, 32'hA5, 32'h11);
        chk("t1_we_cnt", 64'(obs_we), 64'(1));
        chk("t1_wdata",  64'(obs_wdata), 64'hA5);
        chk("t1_rsp",    64'(obs_rsp), 64'h11);
        chk("t1_idx",    64'(obs_ridx), 64'(0));
        chk("t1_store",  64'(mem[{2'd0, 12'h300}]), 64'hA5);

        // RS with zero operand never writes; nonzero sets bits.
        run_one(1, 2'd1, 12'h301, 2'd0, 32'h0, 32'h7);
        chk("t2_we_cnt", 64'(obs_we), 64'(0));
        chk("t2_rsp",    64'(obs_rsp), 64'h7);
        run_one(1, 2'd1, 12'h301, 2'd0, 32'h8, 32'h7);
        chk("t2b_wdata", 64'(obs_wdata), 64'hF);

        // RC clears bits; RO returns the value and never writes.
        run_one(2, 2'd2, 12'h302, 2'd1, 32'h3, 32'hF);
        chk("t3_wdata", 64'(obs_wdata), 64'hC);
        run_one(3, 2'd3, 12'h303, 2'd2, 32'hFFFF, 32'h1234);
        chk("t3b_we_cnt", 64'(obs_we), 64'(0));
        chk("t3b_rsp",    64'(obs_rsp), 64'h1234);

        // All requesters held valid: round-robin from index 0, one grant per 4 clocks.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 2'd3, 12'h310 + 12'(i), 2'd0, 32'h0, UW'(i));
        rsp_ready = 1'b1;
        grants_q.delete();
        repeat (16) tick();
        chk("t4_grants", 64'(grants_q.size()), 64'(4));
        for (int i = 0; i < 4; i++) chk("t4_order", 64'(grants_q[i]), 64'(i));
        req_valid = '0;

        // Response stall of five clocks, then grant right after the handshake.
        clear_obs();
        set_req(2, 2'd0, 12'h320, 2'd3, 32'h5A5A, UW'(44'hABC));
        tick();
        req_valid[2] = 1'b0;
        set_req(0, 2'd3, 12'h321, 2'd0, 32'h0, UW'(44'h123));
        tick();
        rsp_ready = 1'b0;
        repeat (6) tick();
        chk("t5_rsp_cycles", 64'(obs_rv), 64'(6));
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("t5_regrant", 64'(grants_q[grants_q.size()-1]), 64'(0));
        req_valid = '0;
        repeat (3) tick();

        // Reset during READ drops the request; pending req0 wins after release.
        preset(2'd0, 12'h300, 32'h99);
        set_req(1, 2'd0, 12'h300, 2'd0, 32'h55, UW'(44'h55));
        tick();
        req_valid[1] = 1'b0;
        chk("t6_in_read", 64'(read_enable), 64'(1));
        set_req(0, 2'd3, 12'h300, 2'd0, 32'h0, UW'(44'h66));
        set_req(2, 2'd3, 12'h301, 2'd0, 32'h0, UW'(44'h77));
        reset = 1'b0;
        #1;
        check_outputs_zero("t6");
        @(negedge clk);
        @(negedge clk);
        chk("t6_no_write", 64'(mem[{2'd0, 12'h300}]), 64'h99);
        model_reset();
        reset = 1'b1;
        tick();
        chk("t6_first", 64'(grants_q[grants_q.size()-1]), 64'(0));
        req_valid = '0;
        repeat (3) tick();

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (gnt_mask[i]) begin
                    if ($urandom_range(0, 1) == 0) rand_req(i);
                    else req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 9) < 3) begin
                    rand_req(i);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
